// File: rtl/bcd_counter_n_if.sv
// Control/status bundle for bcd_counter_n. The seg field exists only when
// BCD_COUNTER_SEG7_EN is defined.
interface bcd_counter_n_if #(
  parameter int unsigned DIGITS = 5
);
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  up_dn;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcd;
  logic                  running;
  logic                  tick;
  logic                  tc;
`ifdef BCD_COUNTER_SEG7_EN
  logic [7*DIGITS-1:0]   seg;

  modport master (
    output start, stop, clear, up_dn, load, load_val,
    input  bcd, running, tick, tc, seg
  );
  modport slave (
    input  start, stop, clear, up_dn, load, load_val,
    output bcd, running, tick, tc, seg
  );
`else
  modport master (
    output start, stop, clear, up_dn, load, load_val,
    input  bcd, running, tick, tc
  );
  modport slave (
    input  start, stop, clear, up_dn, load, load_val,
    output bcd, running, tick, tc
  );
`endif
endinterface

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with tick prescaler and run/pause/idle control.
// Define BCD_COUNTER_SEG7_EN to add a registered active-low 7-segment output.
module bcd_counter_n #(
  parameter int unsigned DIGITS   = 5,
  parameter int unsigned DIV      = 50000,
  parameter int unsigned SATURATE = 0
) (
  input logic             CLOCK_50,
  input logic             reset,
  bcd_counter_n_if.slave  bus
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = $clog2(DIV);

  typedef enum logic [1:0] {StIdle, StRun, StPaused} state_e;

  state_e          state_q;
  logic [PW-1:0]   pre_q;
  logic [W-1:0]    bcd_q;
  logic            tc_q;

  logic            tick;
  logic [W-1:0]    step_val;
  logic [W-1:0]    load_clamped;
  logic            at_term;

  assign tick = (state_q == StRun) && (pre_q == PW'(DIV - 1));

  // Ripple one decimal step; a carry/borrow out of the top digit marks the terminal value.
  always_comb begin
    logic [3:0] digit;
    logic       carry;
    step_val = bcd_q;
    carry    = 1'b1;
    digit    = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      digit = bcd_q[4*i +: 4];
      if (carry) begin
        if (bus.up_dn) begin
          if (digit >= 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = digit + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = digit - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
    at_term = carry;
  end

  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      load_clamped[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd9 : bus.load_val[4*i +: 4];
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pre_q   <= '0;
      bcd_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.clear) begin
        state_q <= StIdle;
        pre_q   <= '0;
        bcd_q   <= '0;
      end else if (state_q == StRun) begin
        pre_q <= tick ? '0 : pre_q + 1'b1;
        if (bus.stop) begin
          state_q <= StPaused;
        end else if (tick) begin
          tc_q <= at_term;
          if (at_term && (SATURATE != 0)) begin
            state_q <= StPaused;
          end else begin
            bcd_q <= step_val;
          end
        end
      end else if (!bus.stop) begin
        // Leaving PAUSED keeps the prescaler phase; leaving IDLE restarts it.
        if (bus.start) begin
          state_q <= StRun;
          if (state_q == StIdle) begin
            pre_q <= '0;
          end
        end else if (bus.load) begin
          bcd_q <= load_clamped;
        end
      end
    end
  end

  assign bus.bcd     = bcd_q;
  assign bus.running = (state_q == StRun);
  assign bus.tick    = tick;
  assign bus.tc      = tc_q;

`ifdef BCD_COUNTER_SEG7_EN
  function automatic logic [6:0] seg_of(logic [3:0] d);
    case (d)
      4'h0:    seg_of = 7'b1000000;
      4'h1:    seg_of = 7'b1111001;
      4'h2:    seg_of = 7'b0100100;
      4'h3:    seg_of = 7'b0110000;
      4'h4:    seg_of = 7'b0011001;
      4'h5:    seg_of = 7'b0010010;
      4'h6:    seg_of = 7'b0000010;
      4'h7:    seg_of = 7'b1111000;
      4'h8:    seg_of = 7'b0000000;
      4'h9:    seg_of = 7'b0010000;
      4'hA:    seg_of = 7'b0001000;
      4'hB:    seg_of = 7'b0000011;
      4'hC:    seg_of = 7'b1000110;
      4'hD:    seg_of = 7'b0100001;
      4'hE:    seg_of = 7'b0000110;
      default: seg_of = 7'b0001110;
    endcase
  endfunction

  logic [7*DIGITS-1:0] seg_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      seg_q <= '1;
    end else begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        seg_q[7*i +: 7] <= seg_of(bcd_q[4*i +: 4]);
      end
    end
  end

  assign bus.seg = seg_q;
`endif
endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: a wrapping and a saturating instance share stimulus and
// are compared each cycle against an integer-valued reference model.
module tb_bcd_counter_n;
  localparam int DIGITS = 3;
  localparam int DIV    = 4;
  localparam int MAXV   = 999;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_counter_n_if #(.DIGITS(DIGITS)) bw ();
  bcd_counter_n_if #(.DIGITS(DIGITS)) bs ();

  bcd_counter_n #(.DIGITS(DIGITS), .DIV(DIV), .SATURATE(0)) u_wrap (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bw.slave)
  );

  bcd_counter_n #(.DIGITS(DIGITS), .DIV(DIV), .SATURATE(1)) u_sat (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bs.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model per instance: 0 = wrap, 1 = saturate. State 0 idle, 1 run, 2 paused.
  int m_st[2];
  int m_pre[2];
  int m_val[2];
  bit m_tc[2];
  bit up_g;

  function automatic logic [11:0] to_bcd(int v);
    return 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic int clamp_val(logic [11:0] lv);
    int r = 0;
    int n;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      r = r * 10 + n;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k]  = 0;
      m_pre[k] = 0;
      m_val[k] = 0;
      m_tc[k]  = 1'b0;
    end
  endtask

  task automatic model_edge(bit s, bit p, bit c, bit u, bit l, logic [11:0] lv);
    bit tk;
    int nv;
    for (int k = 0; k < 2; k++) begin
      tk      = (m_st[k] == 1) && (m_pre[k] == DIV - 1);
      m_tc[k] = 1'b0;
      if (c) begin
        m_st[k]  = 0;
        m_pre[k] = 0;
        m_val[k] = 0;
      end else if (m_st[k] == 1) begin
        m_pre[k] = (m_pre[k] + 1) % DIV;
        if (p) begin
          m_st[k] = 2;
        end else if (tk) begin
          nv = u ? m_val[k] + 1 : m_val[k] - 1;
          if (nv > MAXV || nv < 0) begin
            m_tc[k] = 1'b1;
            if (k == 1) m_st[k] = 2;
            else m_val[k] = (nv + MAXV + 1) % (MAXV + 1);
          end else begin
            m_val[k] = nv;
          end
        end
      end else if (!p) begin
        if (s) begin
          if (m_st[k] == 0) m_pre[k] = 0;
          m_st[k] = 1;
        end else if (l) begin
          m_val[k] = clamp_val(lv);
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, " wrap bcd"}, 32'(bw.bcd), 32'(to_bcd(m_val[0])));
    chk({tag, " wrap running"}, 32'(bw.running), 32'(m_st[0] == 1));
    chk({tag, " wrap tc"}, 32'(bw.tc), 32'(m_tc[0]));
    chk({tag, " wrap tick"}, 32'(bw.tick), 32'((m_st[0] == 1) && (m_pre[0] == DIV - 1)));
    chk({tag, " sat bcd"}, 32'(bs.bcd), 32'(to_bcd(m_val[1])));
    chk({tag, " sat running"}, 32'(bs.running), 32'(m_st[1] == 1));
    chk({tag, " sat tc"}, 32'(bs.tc), 32'(m_tc[1]));
    chk({tag, " sat tick"}, 32'(bs.tick), 32'((m_st[1] == 1) && (m_pre[1] == DIV - 1)));
  endtask

  // Called just after a falling edge: drive inputs, advance the model, check at next fall.
  task automatic cyc(bit s, bit p, bit c, bit l, logic [11:0] lv, string tag);
    bw.start = s;  bs.start = s;
    bw.stop  = p;  bs.stop  = p;
    bw.clear = c;  bs.clear = c;
    bw.load  = l;  bs.load  = l;
    bw.load_val = lv;  bs.load_val = lv;
    bw.up_dn = up_g;   bs.up_dn = up_g;
    model_edge(s, p, c, up_g, l, lv);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_n(int n, string tag);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, tag);
  endtask

  initial begin
    rst  = 1'b1;
    up_g = 1'b1;
    bw.start = 1'b0; bw.stop = 1'b0; bw.clear = 1'b0; bw.load = 1'b0;
    bw.load_val = '0; bw.up_dn = 1'b1;
    bs.start = 1'b0; bs.stop = 1'b0; bs.clear = 1'b0; bs.load = 1'b0;
    bs.load_val = '0; bs.up_dn = 1'b1;
    model_reset();
    @(negedge clk);
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    check_all("reset release");

    // Free count from idle: ten steps in forty clocks
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, "t1 start");
    idle_n(40, "t1 run");
    chk("t1 bcd", 32'(bw.bcd), 32'h010);
    chk("t1 running", 32'(bw.running), 32'd1);

    // Asynchronous reset between edges
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, "t2 clear");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, "t2 start");
    idle_n(20, "t2 run");
    chk("t2 pre bcd", 32'(bw.bcd), 32'h005);
    #2 rst = 1'b1;
    #1;
    chk("t2 async bcd", 32'(bw.bcd), 32'h000);
    chk("t2 async running", 32'(bw.running), 32'd0);
    chk("t2 async sat bcd", 32'(bs.bcd), 32'h000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all("t2 released");
    idle_n(12, "t2 no start");
    chk("t2 still zero", 32'(bw.bcd), 32'h000);

    // Pause in a tick cycle, load near the top and roll over
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, "t3 start");
    idle_n(3, "t3 run");
    chk("t3 tick before stop", 32'(bw.tick), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, "t3 stop");
    chk("t3 stop no step", 32'(bw.bcd), 32'h000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'h998, "t3 load");
    chk("t3 load", 32'(bw.bcd), 32'h998);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, "t3 resume");
    idle_n(4, "t3 run");
    chk("t3 bcd 999", 32'(bw.bcd), 32'h999);
    idle_n(4, "t3 run");
    chk("t3 wrap bcd", 32'(bw.bcd), 32'h000);
    chk("t3 wrap tc", 32'(bw.tc), 32'd1);
    chk("t3 wrap running", 32'(bw.running), 32'd1);
    chk("t3 sat bcd", 32'(bs.bcd), 32'h999);
    chk("t3 sat tc", 32'(bs.tc), 32'd1);
    chk("t3 sat running", 32'(bs.running), 32'd0);
    idle_n(1, "t3 after");
    chk("t3 tc one cycle", 32'(bw.tc), 32'd0);

    // Saturated instance holds, then clamps a load
    idle_n(20, "t5 hold");
    chk("t5 sat hold", 32'(bs.bcd), 32'h999);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'h9F3, "t5 load");
    chk("t5 sat clamp", 32'(bs.bcd), 32'h993);

    // Count down through zero
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, "t4 clear");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, "t4 load");
    up_g = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, "t4 start");
    idle_n(4, "t4 run");
    chk("t4 wrap bcd", 32'(bw.bcd), 32'h999);
    chk("t4 wrap tc", 32'(bw.tc), 32'd1);
    chk("t4 sat bcd", 32'(bs.bcd), 32'h000);
    chk("t4 sat running", 32'(bs.running), 32'd0);
    idle_n(4, "t4 run");
    chk("t4 wrap 998", 32'(bw.bcd), 32'h998);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, "t4 restart sat");
    idle_n(4, "t4 resat");
    chk("t4 resat tc", 32'(bs.tc), 32'd1);
    chk("t4 resat bcd", 32'(bs.bcd), 32'h000);
    chk("t4 resat running", 32'(bs.running), 32'd0);

    // stop in tick cycle, start+stop while paused, clear with start
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, "t6 clear");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, "t6 start");
    idle_n(3, "t6 run");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, "t6 stop");
    chk("t6 no step", 32'(bw.bcd), 32'h000);
    chk("t6 paused", 32'(bw.running), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'h000, "t6 start+stop");
    chk("t6 stays paused", 32'(bw.running), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, "t6 resume");
    idle_n(3, "t6 run");
    chk("t6 not yet", 32'(bw.bcd), 32'h000);
    idle_n(1, "t6 run");
    chk("t6 first step", 32'(bw.bcd), 32'h999);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, "t6 clear+start");
    chk("t6 clear running", 32'(bw.running), 32'd0);
    chk("t6 clear bcd", 32'(bw.bcd), 32'h000);

    // Randomised control traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) up_g = ~up_g;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 5) == 0, 12'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
